onehot_decoder_seq: RTL and testbench

- Counterpart to the team's priority encoder: converts an encoded index back into a one-hot line vector.
- Encoded requests (index plus enable) enter through a valid/ready handshake and are buffered in a small FIFO.
- Each request is replayed as a one-hot output held for a programmable number of cycles.
- Used to drive select/strobe lines from encoded grants produced upstream.

---
 rtl/onehot_decoder_seq_pkg.sv | 21 ++
 rtl/onehot_decoder_seq_if.sv | 16 +
 rtl/onehot_decoder_seq_sync_fifo.sv | 59 +++++
 rtl/onehot_decoder_seq.sv | 136 +++++++++++++
 tb/tb_onehot_decoder_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_decoder_seq_pkg.sv
// Shared definitions for the one-hot decoder: default widths, FSM state
// encoding and the layout of a queued request.
package onehot_decoder_seq_pkg;

  localparam int unsigned IDX_W_DEF  = 2;
  localparam int unsigned OUT_W_DEF  = 4;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned HOLD_W_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Queued request at default widths; enable sits above the index.
  typedef struct packed {
    logic                 en;
    logic [IDX_W_DEF-1:0] idx;
  } entry_t;

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Valid/ready request channel carrying an encoded index plus decoder enable.
interface onehot_decoder_seq_if
  import onehot_decoder_seq_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_en;

  modport master (output in_valid, in_idx, in_en, input in_ready);
  modport slave  (input in_valid, in_idx, in_en, output in_ready);

endinterface

// File: rtl/onehot_decoder_seq_sync_fifo.sv
// Single-clock FIFO with registered occupancy, synchronous flush and a
// first-word-fall-through read port.
module onehot_decoder_seq_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Buffers encoded index requests and replays each one as a one-hot
// strobe held for a programmable number of cycles.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  onehot_decoder_seq_if.slave    bus,
  input  logic [HOLD_W-1:0]      hold_len,
  output logic [OUT_W-1:0]       out_onehot,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err
);

  localparam int unsigned ENT_W = IDX_W + 1;

  if (OUT_W != (32'd1 << IDX_W)) begin : g_width_check
    $error("onehot_decoder_seq: OUT_W must equal 2**IDX_W");
  end

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [OUT_W-1:0]  onehot_d;
  logic              valid_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  wr_entry;
  logic [ENT_W-1:0]  rd_entry;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;

  // Entry layout matches entry_t: enable above index.
  assign wr_entry     = {bus.in_en, bus.in_idx};
  assign rd_en        = rd_entry[IDX_W];
  assign rd_idx       = rd_entry[IDX_W-1:0];
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full && !clr;

  onehot_decoder_seq_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hcnt_q     <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      out_onehot <= onehot_d;
      out_valid  <= valid_d;
    end
  end

  // Next state; a pop always coincides with reloading the outputs.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    onehot_d = out_onehot;
    valid_d  = out_valid;
    pop      = 1'b0;

    if (clr) begin
      state_d  = ST_IDLE;
      hcnt_d   = '0;
      onehot_d = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hcnt_q > HOLD_W'(1)) begin
            hcnt_d = hcnt_q - HOLD_W'(1);
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            hcnt_d   = '0;
            onehot_d = '0;
            valid_d  = 1'b0;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          hcnt_d   = '0;
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      endcase

      if (pop) begin
        onehot_d = rd_en ? (OUT_W'(1) << rd_idx) : '0;
        valid_d  = 1'b1;
        hcnt_d   = (hold_len == '0) ? HOLD_W'(1) : hold_len;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (bus.in_valid && fifo_full) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: a per-cycle vector table plus
// hand-written sequences for stall, flush and asynchronous reset.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] hold_len;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic [2:0] count;
  logic       ovf_err;

  int vectors = 0;
  int errors  = 0;

  onehot_decoder_seq_if #(.IDX_W(2)) bus ();

  onehot_decoder_seq #(
    .IDX_W  (2),
    .OUT_W  (4),
    .DEPTH  (4),
    .HOLD_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .bus        (bus),
    .hold_len   (hold_len),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .count      (count),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
    logic       en;
    logic [3:0] hold;
    logic [3:0] e_oh;
    logic       e_v;
    logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [1:0] idx, input logic en,
                              input logic [3:0] hold, input logic [3:0] oh,
                              input logic v, input logic [2:0] c);
    vec_t r;
    r.vld = vld; r.idx = idx; r.en = en; r.hold = hold;
    r.e_oh = oh; r.e_v = v; r.e_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] i, input logic e);
    bus.in_valid = v;
    bus.in_idx   = i;
    bus.in_en    = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl [18];
  int   pushed;
  logic rdy;
  int   sel;
  logic [31:0] exp_oh;

  initial begin
    // Vector table: inputs before the edge, expected outputs after it.
    tbl[0]  = mk(1'b1, 2'd2, 1'b1, 4'd3, 4'b0000, 1'b0, 3'd1);
    tbl[1]  = mk(1'b0, 2'd0, 1'b0, 4'd3, 4'b0100, 1'b1, 3'd0);
    tbl[2]  = mk(1'b0, 2'd0, 1'b0, 4'd3, 4'b0100, 1'b1, 3'd0);
    tbl[3]  = mk(1'b0, 2'd0, 1'b0, 4'd3, 4'b0100, 1'b1, 3'd0);
    tbl[4]  = mk(1'b0, 2'd0, 1'b0, 4'd3, 4'b0000, 1'b0, 3'd0);
    tbl[5]  = mk(1'b1, 2'd0, 1'b1, 4'd1, 4'b0000, 1'b0, 3'd1);
    tbl[6]  = mk(1'b1, 2'd1, 1'b1, 4'd1, 4'b0001, 1'b1, 3'd1);
    tbl[7]  = mk(1'b1, 2'd2, 1'b1, 4'd1, 4'b0010, 1'b1, 3'd1);
    tbl[8]  = mk(1'b1, 2'd3, 1'b1, 4'd1, 4'b0100, 1'b1, 3'd1);
    tbl[9]  = mk(1'b0, 2'd0, 1'b0, 4'd1, 4'b1000, 1'b1, 3'd0);
    tbl[10] = mk(1'b0, 2'd0, 1'b0, 4'd1, 4'b0000, 1'b0, 3'd0);
    tbl[11] = mk(1'b1, 2'd3, 1'b0, 4'd0, 4'b0000, 1'b0, 3'd1);
    tbl[12] = mk(1'b0, 2'd0, 1'b0, 4'd0, 4'b0000, 1'b1, 3'd0);
    tbl[13] = mk(1'b0, 2'd0, 1'b0, 4'd0, 4'b0000, 1'b0, 3'd0);
    tbl[14] = mk(1'b1, 2'd1, 1'b1, 4'd2, 4'b0000, 1'b0, 3'd1);
    tbl[15] = mk(1'b0, 2'd0, 1'b0, 4'd2, 4'b0010, 1'b1, 3'd0);
    tbl[16] = mk(1'b0, 2'd0, 1'b0, 4'd5, 4'b0010, 1'b1, 3'd0);
    tbl[17] = mk(1'b0, 2'd0, 1'b0, 4'd5, 4'b0000, 1'b0, 3'd0);

    rst = 1'b1;
    clr = 1'b0;
    hold_len = 4'd0;
    drive(1'b0, 2'd0, 1'b0);
    step();
    step();
    chk("reset out_onehot", 32'(out_onehot), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset count", 32'(count), 0);
    chk("reset ovf_err", 32'(ovf_err), 0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].vld, tbl[i].idx, tbl[i].en);
      hold_len = tbl[i].hold;
      step();
      chk($sformatf("row%0d out_onehot", i), 32'(out_onehot), 32'(tbl[i].e_oh));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
      chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 1);
      chk($sformatf("row%0d ovf_err", i), 32'(ovf_err), 0);
    end
    drive(1'b0, 2'd0, 1'b0);

    // Six entries with hold 4: FIFO fills, one stalled cycle, replay in order.
    hold_len = 4'd4;
    pushed = 0;
    for (int k = 1; k <= 26; k++) begin
      if (pushed < 6) drive(1'b1, 2'(pushed % 4), 1'b1);
      else            drive(1'b0, 2'd0, 1'b0);
      rdy = bus.in_ready;
      step();
      if (bus.in_valid && rdy) pushed++;
      if (k < 2 || k > 25) begin
        exp_oh = 0;
      end else begin
        sel    = ((k - 2) / 4) % 4;
        exp_oh = 32'(1) << sel;
      end
      chk($sformatf("stall k%0d out_onehot", k), 32'(out_onehot), exp_oh);
      if (k == 5) begin
        chk("stall full count", 32'(count), 4);
        chk("stall in_ready", 32'(bus.in_ready), 0);
      end
      if (k == 6) chk("stall ovf_err", 32'(ovf_err), 1);
    end
    chk("stall accepted", 32'(pushed), 6);
    chk("stall drained valid", 32'(out_valid), 0);
    drive(1'b0, 2'd0, 1'b0);

    // Flush during a hold with a simultaneous push.
    drive(1'b1, 2'd2, 1'b1);
    step();
    drive(1'b1, 2'd1, 1'b1);
    step();
    drive(1'b1, 2'd3, 1'b1);
    step();
    chk("clr pre out_onehot", 32'(out_onehot), 32'b0100);
    chk("clr pre count", 32'(count), 2);
    clr = 1'b1;
    drive(1'b1, 2'd0, 1'b1);
    step();
    clr = 1'b0;
    drive(1'b0, 2'd0, 1'b0);
    chk("clr out_valid", 32'(out_valid), 0);
    chk("clr out_onehot", 32'(out_onehot), 0);
    chk("clr count", 32'(count), 0);
    chk("clr ovf_err kept", 32'(ovf_err), 1);
    step();
    step();
    chk("clr push dropped valid", 32'(out_valid), 0);
    chk("clr push dropped count", 32'(count), 0);

    // Asynchronous reset mid-hold with three entries queued.
    drive(1'b1, 2'd0, 1'b1);
    step();
    drive(1'b1, 2'd1, 1'b1);
    step();
    drive(1'b1, 2'd2, 1'b1);
    step();
    drive(1'b1, 2'd3, 1'b1);
    step();
    drive(1'b0, 2'd0, 1'b0);
    chk("rst pre count", 32'(count), 3);
    chk("rst pre out_onehot", 32'(out_onehot), 32'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_onehot", 32'(out_onehot), 0);
    chk("async rst out_valid", 32'(out_valid), 0);
    chk("async rst count", 32'(count), 0);
    chk("async rst ovf_err", 32'(ovf_err), 0);
    chk("async rst in_ready", 32'(bus.in_ready), 1);
    step();
    rst = 1'b0;
    hold_len = 4'd1;
    drive(1'b1, 2'd1, 1'b1);
    step();
    drive(1'b0, 2'd0, 1'b0);
    chk("after rst count", 32'(count), 1);
    step();
    chk("after rst out_onehot", 32'(out_onehot), 32'b0010);
    chk("after rst out_valid", 32'(out_valid), 1);
    step();
    chk("after rst drained", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
